// File: rtl/reg_status_rat_pkg.sv
// Shared widths, index/tag types and the "no pending producer" tag for the
// merged architectural register file / register alias table.
package reg_status_rat_pkg;

    localparam int NREGS      = 32;
    localparam int DATA_W     = 32;
    localparam int ROBEN_W    = 5;
    localparam int NREGS_BITS = $clog2(NREGS);

    typedef logic [NREGS_BITS-1:0] reg_idx_t;
    typedef logic [ROBEN_W-1:0]    roben_t;
    typedef logic [DATA_W-1:0]     data_t;

    // Tag value meaning "the stored data is the committed value".
    localparam roben_t NULL_ROBEN = '0;

endpackage

// File: rtl/reg_status_rat_read_port.sv
// One issue read port: stored data/tag, overridden by a same-cycle commit
// that retires the very producer this register is waiting on.
module rat_read_port
    import reg_status_rat_pkg::*;
(
    input  reg_idx_t addr,
    input  data_t    stored_data,
    input  roben_t   stored_tag,
    input  logic     commit_we,
    input  reg_idx_t commit_rd,
    input  roben_t   commit_roben,
    input  data_t    commit_data,
    output data_t    data,
    output roben_t   tag
);

    logic bypass;

    // commit_we already excludes r0, so r0 can never be bypassed.
    assign bypass = commit_we && (addr == commit_rd) && (stored_tag == commit_roben);

    assign data = bypass ? commit_data : stored_data;
    assign tag  = bypass ? NULL_ROBEN  : stored_tag;

endmodule

// File: rtl/reg_status_rat.sv
// Architectural register file merged with the register alias table: renames
// tag Rd with its ROBEN, commits write data and clear the tag if still owned.
module reg_status_rat
    import reg_status_rat_pkg::*;
(
    input  logic     clk,
    input  logic     rst,

    input  logic     Rename_Valid,
    input  reg_idx_t Rename_Rd,
    input  logic     Rename_RegWrite,
    input  roben_t   Rename_ROBEN,

    input  reg_idx_t RP_Rs,
    input  reg_idx_t RP_Rt,
    output data_t    RP_Rs_Data,
    output data_t    RP_Rt_Data,
    output roben_t   RP_Rs_ROBEN,
    output roben_t   RP_Rt_ROBEN,

    input  logic     Commit_Valid,
    input  logic     Commit_RegWrite,
    input  reg_idx_t Commit_Rd,
    input  roben_t   Commit_ROBEN,
    input  data_t    Commit_Write_Data,

    input  logic     FLUSH_Flag,

    input  reg_idx_t index_test,
    output data_t    Reg_Data_test,
    output roben_t   Reg_ROBEN_test
);

    data_t  reg_data [NREGS];
    roben_t reg_tag  [NREGS];

    logic rename_we;
    logic commit_we;

    // Rename_Valid and Commit_Valid are single-cycle strobes with no
    // backpressure: each asserted cycle is exactly one accepted event.
    assign rename_we = Rename_Valid && Rename_RegWrite && (Rename_Rd != '0);
    assign commit_we = Commit_Valid && Commit_RegWrite && (Commit_Rd != '0);

    // r0 is cleared by reset and never written, so it always reads zero.
    // Tag priority: flush, then rename (younger owner wins), then commit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_data[i] <= '0;
                reg_tag[i]  <= NULL_ROBEN;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (commit_we && (Commit_Rd == reg_idx_t'(i)))
                    reg_data[i] <= Commit_Write_Data;

                if (FLUSH_Flag)
                    reg_tag[i] <= NULL_ROBEN;
                else if (rename_we && (Rename_Rd == reg_idx_t'(i)))
                    reg_tag[i] <= Rename_ROBEN;
                else if (commit_we && (Commit_Rd == reg_idx_t'(i)) &&
                         (reg_tag[i] == Commit_ROBEN))
                    reg_tag[i] <= NULL_ROBEN;
            end
        end
    end

    rat_read_port u_rs_port (
        .addr         (RP_Rs),
        .stored_data  (reg_data[RP_Rs]),
        .stored_tag   (reg_tag[RP_Rs]),
        .commit_we    (commit_we),
        .commit_rd    (Commit_Rd),
        .commit_roben (Commit_ROBEN),
        .commit_data  (Commit_Write_Data),
        .data         (RP_Rs_Data),
        .tag          (RP_Rs_ROBEN)
    );

    rat_read_port u_rt_port (
        .addr         (RP_Rt),
        .stored_data  (reg_data[RP_Rt]),
        .stored_tag   (reg_tag[RP_Rt]),
        .commit_we    (commit_we),
        .commit_rd    (Commit_Rd),
        .commit_roben (Commit_ROBEN),
        .commit_data  (Commit_Write_Data),
        .data         (RP_Rt_Data),
        .tag          (RP_Rt_ROBEN)
    );

    // Debug view is the raw stored state, deliberately without the bypass.
    assign Reg_Data_test  = reg_data[index_test];
    assign Reg_ROBEN_test = reg_tag[index_test];

endmodule
